// File: rtl/centroid_pkg.sv
// Shared types and width helpers for the multi-channel centroid engine.
package centroid_pkg;

  // Engine phases: accumulate a frame, then walk the channels emitting results.
  typedef enum logic [2:0] {
    ACCUM,
    LOAD,
    DIV_X,
    DIV_Y,
    EMIT
  } state_e;

  // Width of an x coordinate sum: enough headroom for a saturated counter.
  function automatic int sx_w(input int h_width, input int cnt_width);
    return h_width + cnt_width;
  endfunction

  // Width of a y coordinate sum.
  function automatic int sy_w(input int v_width, input int cnt_width);
    return v_width + cnt_width;
  endfunction

  // Channel index width; a single-channel build still carries a 1-bit index.
  function automatic int ch_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/centroid_multi_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Handshake: start_in is a one-cycle request that samples dividend_in and
// divisor_in; done_out pulses for one cycle exactly WIDTH cycles after the
// start cycle, and quotient_out is valid in that cycle (and holds until the
// next start). A start while busy restarts the division.
module divider_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic             done_out
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] rem_src, quo_src, dvs_src, rem_shift, new_rem, new_quo;
  logic             ge;

  // One restoring step per cycle; the start cycle already performs the first step.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;

    rem_src = start_in ? '0          : rem_q;
    quo_src = start_in ? dividend_in : quo_q;
    dvs_src = start_in ? divisor_in  : dvs_q;

    // The shifted remainder is WIDTH+1 bits wide; its top bit alone proves
    // it is at least the divisor, and the WIDTH-bit difference is then exact.
    rem_shift = {rem_src[WIDTH-2:0], quo_src[WIDTH-1]};
    ge        = rem_src[WIDTH-1] | (rem_shift >= dvs_src);
    new_rem   = ge ? (rem_shift - dvs_src) : rem_shift;
    new_quo   = {quo_src[WIDTH-2:0], ge};

    if (start_in) begin
      rem_d  = new_rem;
      quo_d  = new_quo;
      dvs_d  = divisor_in;
      cnt_d  = CW'(WIDTH - 1);
      busy_d = 1'b1;
    end else if (busy_q && (cnt_q != '0)) begin
      rem_d = new_rem;
      quo_d = new_quo;
      cnt_d = cnt_q - CW'(1);
    end else if (busy_q) begin
      busy_d = 1'b0;
    end
  end

  // Divider state register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign quotient_out = quo_q;
  assign done_out     = busy_q && (cnt_q == '0);

endmodule

// File: rtl/centroid_multi.sv
// Multi-channel centroid engine: per-channel coordinate sums and pixel counts
// are accumulated over a frame; a tabulate pulse then emits one result per
// channel in channel order through a single shared iterative divider.
// valid_out is a one-cycle strobe with no back-pressure; result outputs hold
// until the next strobe. Pixels and tabulate pulses arriving while busy_out
// is high are dropped.
module centroid_multi
  import centroid_pkg::*;
#(
  parameter int H_WIDTH   = 11,
  parameter int V_WIDTH   = 10,
  parameter int NUM_CH    = 4,
  parameter int MIN_MASS  = 1,
  parameter int CNT_WIDTH = H_WIDTH + V_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [H_WIDTH-1:0]        x_in,
  input  logic [V_WIDTH-1:0]        y_in,
  input  logic [ch_w(NUM_CH)-1:0]   ch_in,
  input  logic                      valid_in,
  input  logic                      tabulate_in,
  output logic [H_WIDTH-1:0]        x_out,
  output logic [V_WIDTH-1:0]        y_out,
  output logic [ch_w(NUM_CH)-1:0]   ch_out,
  output logic                      found_out,
  output logic                      valid_out,
  output logic                      busy_out
);

  localparam int SX_W  = sx_w(H_WIDTH, CNT_WIDTH);
  localparam int SY_W  = sy_w(V_WIDTH, CNT_WIDTH);
  localparam int CH_W  = ch_w(NUM_CH);
  localparam int DIV_W = SX_W;

  state_e               state_q, state_d;
  logic [CH_W-1:0]      k_q, k_d;
  logic [SX_W-1:0]      sx_q  [NUM_CH];
  logic [SX_W-1:0]      sx_d  [NUM_CH];
  logic [SY_W-1:0]      sy_q  [NUM_CH];
  logic [SY_W-1:0]      sy_d  [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];
  logic [H_WIDTH-1:0]   x_res_q, x_res_d;
  logic                 start_q, start_d;
  logic [H_WIDTH-1:0]   x_out_q, x_out_d;
  logic [V_WIDTH-1:0]   y_out_q, y_out_d;
  logic [CH_W-1:0]      ch_out_q, ch_out_d;
  logic                 found_q, found_d;
  logic                 valid_q, valid_d;

  logic [DIV_W-1:0]     div_dividend, div_divisor, div_quotient;
  logic                 div_done;
  logic                 pix_ok;
  logic                 unused_quo_hi;

  // Divider operands follow the current phase: x sum in DIV_X, y sum in DIV_Y.
  always_comb begin
    div_dividend = (state_q == DIV_Y) ? DIV_W'(sy_q[k_q]) : sx_q[k_q];
    div_divisor  = DIV_W'(cnt_q[k_q]);
  end

  // Quotient bits above the coordinate width are never needed.
  assign unused_quo_hi = ^div_quotient[DIV_W-1:H_WIDTH];

  divider_iter #(
    .WIDTH (DIV_W)
  ) u_div (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (start_q),
    .dividend_in  (div_dividend),
    .divisor_in   (div_divisor),
    .quotient_out (div_quotient),
    .done_out     (div_done)
  );

  // Next-state, accumulation and result-register logic.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    cnt_d    = cnt_q;
    x_res_d  = x_res_q;
    start_d  = 1'b0;
    x_out_d  = x_out_q;
    y_out_d  = y_out_q;
    ch_out_d = ch_out_q;
    found_d  = found_q;
    valid_d  = 1'b0;

    // Out-of-range channels and saturated counters drop the pixel.
    pix_ok = valid_in && (int'(ch_in) < NUM_CH) && !(&cnt_q[ch_in]);

    case (state_q)
      ACCUM: begin
        if (pix_ok) begin
          sx_d[ch_in]  = sx_q[ch_in] + SX_W'(x_in);
          sy_d[ch_in]  = sy_q[ch_in] + SY_W'(y_in);
          cnt_d[ch_in] = cnt_q[ch_in] + CNT_WIDTH'(1);
        end
        if (tabulate_in) begin
          state_d = LOAD;
          k_d     = '0;
        end
      end
      LOAD: begin
        if (cnt_q[k_q] < CNT_WIDTH'(MIN_MASS)) begin
          x_out_d  = '0;
          y_out_d  = '0;
          ch_out_d = k_q;
          found_d  = 1'b0;
          valid_d  = 1'b1;
          state_d  = EMIT;
        end else begin
          start_d = 1'b1;
          state_d = DIV_X;
        end
      end
      DIV_X: begin
        if (div_done) begin
          x_res_d = div_quotient[H_WIDTH-1:0];
          start_d = 1'b1;
          state_d = DIV_Y;
        end
      end
      DIV_Y: begin
        if (div_done) begin
          x_out_d  = x_res_q;
          y_out_d  = div_quotient[V_WIDTH-1:0];
          ch_out_d = k_q;
          found_d  = 1'b1;
          valid_d  = 1'b1;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        sx_d[k_q]  = '0;
        sy_d[k_q]  = '0;
        cnt_d[k_q] = '0;
        if (k_q == CH_W'(NUM_CH - 1)) begin
          state_d = ACCUM;
        end else begin
          k_d     = k_q + CH_W'(1);
          state_d = LOAD;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State, accumulators and output registers; reset aborts any emission.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ACCUM;
      k_q      <= '0;
      x_res_q  <= '0;
      start_q  <= 1'b0;
      x_out_q  <= '0;
      y_out_q  <= '0;
      ch_out_q <= '0;
      found_q  <= 1'b0;
      valid_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        sx_q[i]  <= '0;
        sy_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      x_res_q  <= x_res_d;
      start_q  <= start_d;
      x_out_q  <= x_out_d;
      y_out_q  <= y_out_d;
      ch_out_q <= ch_out_d;
      found_q  <= found_d;
      valid_q  <= valid_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign ch_out    = ch_out_q;
  assign found_out = found_q;
  assign valid_out = valid_q;
  assign busy_out  = (state_q != ACCUM);

endmodule

// File: doc/centroid_multi.md
Name: centroid_multi

Overview:
- Multi-channel, parametrised centroid engine for the camera/tracking pipeline.
- Accumulates per-channel (colour-class) pixel coordinate sums and counts over a frame.
- On a tabulate pulse, emits one centroid result per channel, in channel order, using a single shared iterative divider.
- Sits after the pixel classifier and before the tracking/render logic. Adds a minimum-mass qualifier and a busy/drop policy.

Parameters:
- H_WIDTH, 11, horizontal coordinate width.
- V_WIDTH, 10, vertical coordinate width.
- NUM_CH, 4, number of independent channels (>=1).
- MIN_MASS, 1, minimum pixel count for a channel to report found (>=1).
- CNT_WIDTH, H_WIDTH+V_WIDTH, per-channel pixel counter width.

Ports:
- clk_in  in  1  system clock; the single clock domain.
- rst_in  in  1  synchronous, active-high reset.
- x_in  in  H_WIDTH  pixel x coordinate.
- y_in  in  V_WIDTH  pixel y coordinate.
- ch_in  in  $clog2(NUM_CH) (min 1)  channel of the pixel.
- valid_in  in  1  pixel qualifier.
- tabulate_in  in  1  end-of-frame pulse; starts result emission.
- x_out  out  H_WIDTH  centroid x (truncated quotient).
- y_out  out  V_WIDTH  centroid y (truncated quotient).
- ch_out  out  $clog2(NUM_CH)  channel of the current result.
- found_out  out  1  channel count >= MIN_MASS.
- valid_out  out  1  one-cycle result strobe.
- busy_out  out  1  high whenever the state is not ACCUM.

Behaviour:
- Reset: all outputs 0; all sums and counts 0; state ACCUM. A reset mid-operation aborts emission immediately; no further valid_out.
- Sum widths: SX_W = H_WIDTH+CNT_WIDTH, SY_W = V_WIDTH+CNT_WIDTH. No overflow is possible while the count is unsaturated.
- ACCUM, valid_in=1: sums[ch_in] += x_in / y_in and cnt[ch_in] += 1, registered next edge.
  - ch_in >= NUM_CH: pixel dropped.
  - cnt[ch_in] at all-ones: pixel dropped (saturate; sums frozen).
- ACCUM, tabulate_in=1: go to LOAD with channel index k=0.
  - If valid_in is also high in that cycle, that pixel is accumulated first and counts toward this frame.
- LOAD:
  - cnt[k] < MIN_MASS: go to EMIT with result 0,0 and found=0, no division.
  - Otherwise start the divider on sx[k]/cnt[k] and go to DIV_X.
- DIV_X: wait for divider done, latch the low H_WIDTH bits of the quotient, start sy[k]/cnt[k], go to DIV_Y.
- DIV_Y: wait for done, latch the low V_WIDTH bits, go to EMIT.
- EMIT:
  - Drive x_out, y_out, ch_out=k and found_out; valid_out=1 for exactly this one cycle.
  - Clear sums[k] and cnt[k].
  - If k==NUM_CH-1, go to ACCUM; else k++ and go to LOAD.
- Output hold: outputs hold their values after the strobe until the next EMIT. Only valid_out returns to 0.
- While busy_out=1: valid_in pixels and tabulate_in are ignored (dropped). There is no queuing.
- Divider latency: done asserts exactly DIV_W cycles after the start cycle, DIV_W = SX_W.
  - The y division uses the same latency, with the dividend zero-extended.
- Per-channel latency, found channel: 1 (LOAD) + 2*(DIV_W+1) + 1 (EMIT) cycles.
- Per-channel latency, not-found channel: 2 cycles.
- Quotient: floor(sum/cnt). The divisor is never 0 when the divider is started.

Decomposition:
- Package centroid_pkg:
  - State enum (ACCUM, LOAD, DIV_X, DIV_Y, EMIT).
  - Width helper functions for SX_W, SY_W and channel index width.
- Sub-module divider_iter (parameter WIDTH): restoring, one quotient bit per cycle.
  - Ports: clk_in, rst_in, start_in, dividend_in, divisor_in, quotient_out, done_out (1-cycle pulse).

Test Plan:
1. Ch0 pixels (10,20),(20,40), then tabulate -> first strobe ch=0 x=15 y=30 found=1. Ch1..3 strobe in order with found=0, x=y=0. Exactly NUM_CH strobes in total.
2. Truncation: ch2 pixels (3,5),(4,6) -> ch2 result x=3, y=5.
3. MIN_MASS=3, ch1 has 2 pixels -> ch1 found=0 with x=y=0, emitted 2 cycles after its LOAD. A ch1 with 3 pixels (0,0),(3,3),(6,6) -> x=3, y=3, found=1.
4. valid_in and tabulate_in in the same cycle on ch0 with pixel (100,50) as the only pixel -> result x=100, y=50. Pixels and tabulates presented while busy_out=1 do not affect the current frame or the next frame. Next-frame sums start at 0.
5. Assert rst_in during DIV_X -> the next cycle shows all outputs 0 and busy_out=0. A fresh frame (7,9) on ch3 then yields x=7, y=9.
6. Boundary: 1000 pixels at (2047,1023) on ch0 -> x=2047, y=1023. Measured latency from the tabulate edge to the ch0 strobe equals the specified value.
